// File: rtl/lift_window_if.sv
// Handshake bundle between a sample source, lift_window and the add_shift stage.
//   master: upstream/downstream side (drives in_valid/in_data/out_ready)
//   slave : lift_window side (drives in_ready, the x2/x3/x4 triple and its flags)
// Signals:
//   in_valid/in_ready/in_data      sample input handshake
//   out_valid/out_ready            triple output handshake
//   x2/x3/x4                       even/odd/even triple
//   out_sol/out_eol/out_eof        start-of-row, end-of-row, end-of-frame flags
interface lift_window_if #(
  parameter int unsigned DATA_W = 19
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] x3;
  logic [DATA_W-1:0] x4;
  logic              out_sol;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, x2, x3, x4, out_sol, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, x2, x3, x4, out_sol, out_eol, out_eof
  );
endinterface

// File: rtl/lift_window.sv
// Streaming sequencer feeding the add_shift 5/3 lifting stage. Accepts one row-major sample
// per input handshake and emits, per output beat, the triple (s(2k), s(2k+1), s(2k+2)).
// The last triple of a row mirrors the left even sample into x4.
// Ports:
//   clk  single rising-edge clock
//   rst  synchronous active-high reset
//   bus  lift_window_if.slave: sample input handshake, triple output handshake and flags
module lift_window #(
  parameter int unsigned DATA_W   = 19,
  parameter int unsigned ROW_LEN  = 256,
  parameter int unsigned NUM_ROWS = 256
) (
  input logic          clk,
  input logic          rst,
  lift_window_if.slave bus
);

  localparam int unsigned COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {
    StE0,
    StOdd,
    StEven,
    StOut
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] e_prev_q, e_prev_d;
  logic [DATA_W-1:0] o_cur_q, o_cur_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] x2_q, x2_d;
  logic [DATA_W-1:0] x3_q, x3_d;
  logic [DATA_W-1:0] x4_q, x4_d;
  logic              sol_q, sol_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;

  logic in_fire;
  logic out_fire;
  logic last_col;
  logic last_row;

  assign in_fire  = bus.in_valid && (state_q != StOut);
  assign out_fire = (state_q == StOut) && bus.out_ready;
  assign last_col = (col_q == COL_W'(ROW_LEN - 1));
  assign last_row = (row_q == ROW_W'(NUM_ROWS - 1));

  always_comb begin
    state_d  = state_q;
    e_prev_d = e_prev_q;
    o_cur_d  = o_cur_q;
    col_d    = col_q;
    row_d    = row_q;
    x2_d     = x2_q;
    x3_d     = x3_q;
    x4_d     = x4_q;
    sol_d    = sol_q;
    eol_d    = eol_q;
    eof_d    = eof_q;

    if (in_fire) begin
      col_d = last_col ? '0 : col_q + COL_W'(1);
    end

    unique case (state_q)
      StE0: begin
        if (in_fire) begin
          e_prev_d = bus.in_data;
          state_d  = StOdd;
        end
      end
      StOdd: begin
        if (in_fire) begin
          if (last_col) begin
            // Right edge: symmetric extension reuses the left even sample as x4.
            x2_d    = e_prev_q;
            x3_d    = bus.in_data;
            x4_d    = e_prev_q;
            sol_d   = 1'b0;
            eol_d   = 1'b1;
            eof_d   = last_row;
            state_d = StOut;
          end else begin
            o_cur_d = bus.in_data;
            state_d = StEven;
          end
        end
      end
      StEven: begin
        if (in_fire) begin
          x2_d     = e_prev_q;
          x3_d     = o_cur_q;
          x4_d     = bus.in_data;
          e_prev_d = bus.in_data;
          // s2 lands at col 2, so this is triple k = 0.
          sol_d    = (col_q == COL_W'(2));
          eol_d    = 1'b0;
          eof_d    = 1'b0;
          state_d  = StOut;
        end
      end
      StOut: begin
        if (out_fire) begin
          if (eol_q) begin
            row_d   = last_row ? '0 : row_q + ROW_W'(1);
            state_d = StE0;
          end else begin
            state_d = StOdd;
          end
        end
      end
      default: state_d = StE0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StE0;
      e_prev_q <= '0;
      o_cur_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      x2_q     <= '0;
      x3_q     <= '0;
      x4_q     <= '0;
      sol_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_prev_q <= e_prev_d;
      o_cur_q  <= o_cur_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x2_q     <= x2_d;
      x3_q     <= x3_d;
      x4_q     <= x4_d;
      sol_q    <= sol_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
    end
  end

  assign bus.in_ready  = (state_q != StOut);
  assign bus.out_valid = (state_q == StOut);
  assign bus.x2        = x2_q;
  assign bus.x3        = x3_q;
  assign bus.x4        = x4_q;
  assign bus.out_sol   = sol_q;
  assign bus.out_eol   = eol_q;
  assign bus.out_eof   = eof_q;

endmodule

// File: tb/tb_lift_window.sv
// Bench for lift_window: three instances (ROW_LEN/NUM_ROWS = 4/1, 4/2, 8/3), each fed from
// its own sample queue and checked every cycle against a row-buffer reference model.
module tb_lift_window;

  localparam int unsigned DW = 19;
  localparam int          NI = 3;
  localparam int          LW = 3 * DW + 3;

  function automatic int rl(input int g);
    return (g == 2) ? 8 : 4;
  endfunction

  function automatic int nr(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 3);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          iv   [NI];
  logic [DW-1:0] idat [NI];
  logic          ordy [NI];
  logic          ir   [NI];
  logic          ov   [NI];
  logic [DW-1:0] ox2  [NI];
  logic [DW-1:0] ox3  [NI];
  logic [DW-1:0] ox4  [NI];
  logic          osol [NI];
  logic          oeol [NI];
  logic          oeof [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned RLEN = rl(g);
    localparam int unsigned NROW = nr(g);

    lift_window_if #(.DATA_W(DW)) bus ();

    lift_window #(
      .DATA_W  (DW),
      .ROW_LEN (RLEN),
      .NUM_ROWS(NROW)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.in_valid  = iv[g];
    assign bus.in_data   = idat[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]   = bus.in_ready;
    assign ov[g]   = bus.out_valid;
    assign ox2[g]  = bus.x2;
    assign ox3[g]  = bus.x3;
    assign ox4[g]  = bus.x4;
    assign osol[g] = bus.out_sol;
    assign oeol[g] = bus.out_eol;
    assign oeof[g] = bus.out_eof;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus queues: main writes sbuf/wp, the model advances rp on accepted samples.
  logic [DW-1:0] sbuf [NI][512];
  int            wp   [NI];
  int            rp   [NI];

  // Reference model: current row buffer plus the pending triple, if any.
  logic [DW-1:0] rowb [NI][8];
  int            m_col [NI];
  int            m_row [NI];
  bit            m_pend [NI];
  logic [DW-1:0] m_x2 [NI];
  logic [DW-1:0] m_x3 [NI];
  logic [DW-1:0] m_x4 [NI];
  bit            m_sol [NI];
  bit            m_eol [NI];
  bit            m_eof [NI];

  // Log of DUT triples at each output transfer: {sol, eol, eof, x2, x3, x4}.
  logic [LW-1:0] lg [NI][256];
  int            ln [NI];

  bit chk_en, bub_en, ordy_rnd, ordy_hold;

  initial begin
    int c, k;
    for (int g = 0; g < NI; g++) begin
      rp[g] = 0; m_col[g] = 0; m_row[g] = 0; m_pend[g] = 0;
    end
    forever begin
      @(posedge clk);
      for (int g = 0; g < NI; g++) begin
        if (rst) begin
          m_pend[g] = 0; m_col[g] = 0; m_row[g] = 0;
        end else if (m_pend[g]) begin
          if (ordy[g]) begin
            m_pend[g] = 0;
            if (m_eol[g]) m_row[g] = (m_row[g] == nr(g) - 1) ? 0 : m_row[g] + 1;
          end
        end else if (iv[g]) begin
          c = m_col[g];
          rowb[g][c] = idat[g];
          rp[g]++;
          m_col[g] = (c == rl(g) - 1) ? 0 : c + 1;
          k = -1;
          if (c == rl(g) - 1) begin
            k = rl(g) / 2 - 1;
            m_x2[g] = rowb[g][c-1]; m_x3[g] = rowb[g][c]; m_x4[g] = rowb[g][c-1];
          end else if (c >= 2 && c % 2 == 0) begin
            k = c / 2 - 1;
            m_x2[g] = rowb[g][c-2]; m_x3[g] = rowb[g][c-1]; m_x4[g] = rowb[g][c];
          end
          if (k >= 0) begin
            m_pend[g] = 1;
            m_sol[g]  = (k == 0);
            m_eol[g]  = (k == rl(g) / 2 - 1);
            m_eof[g]  = m_eol[g] && (m_row[g] == nr(g) - 1);
          end
        end
      end
    end
  end

  // Per-cycle compare on the falling edge, then drive the next cycle's inputs.
  initial begin
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; idat[g] = '0; ordy[g] = 1'b0; ln[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (chk_en) begin
          check($sformatf("i%0d_in_ready", g), 32'(ir[g]), 32'(!m_pend[g]));
          check($sformatf("i%0d_out_valid", g), 32'(ov[g]), 32'(m_pend[g]));
          if (m_pend[g]) begin
            check($sformatf("i%0d_x2", g), 32'(ox2[g]), 32'(m_x2[g]));
            check($sformatf("i%0d_x3", g), 32'(ox3[g]), 32'(m_x3[g]));
            check($sformatf("i%0d_x4", g), 32'(ox4[g]), 32'(m_x4[g]));
            check($sformatf("i%0d_sol", g), 32'(osol[g]), 32'(m_sol[g]));
            check($sformatf("i%0d_eol", g), 32'(oeol[g]), 32'(m_eol[g]));
            check($sformatf("i%0d_eof", g), 32'(oeof[g]), 32'(m_eof[g]));
          end
        end
        iv[g]   = (rp[g] < wp[g]) && (!bub_en || ($urandom_range(0, 1) == 1));
        idat[g] = iv[g] ? sbuf[g][rp[g]] : DW'($urandom);
        ordy[g] = ordy_hold ? 1'b0 : (ordy_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        if (ov[g] && ordy[g] && !rst && ln[g] < 256) begin
          lg[g][ln[g]] = {osol[g], oeol[g], oeof[g], ox2[g], ox3[g], ox4[g]};
          ln[g]++;
        end
      end
    end
  end

  task automatic push(input int g, input int v);
    sbuf[g][wp[g]] = DW'(v);
    wp[g]++;
  endtask

  task automatic push_rand(input int g, input int n);
    for (int i = 0; i < n; i++) push(g, int'($urandom_range(0, (1 << DW) - 1)));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input int g, input int n, input int lim);
    int i;
    i = 0;
    while (ln[g] < n && i < lim) begin
      cyc(1);
      i++;
    end
    check($sformatf("i%0d_wait_log", g), 32'(ln[g] >= n), 32'd1);
  endtask

  task automatic wait_drain(input int g, input int lim);
    int i;
    i = 0;
    while ((rp[g] < wp[g] || m_pend[g]) && i < lim) begin
      cyc(1);
      i++;
    end
    check($sformatf("i%0d_drain", g), 32'(rp[g] == wp[g] && !m_pend[g]), 32'd1);
  endtask

  task automatic check_log(input int g, input int i, input int e2, input int e3, input int e4,
                           input bit es, input bit el, input bit ef);
    logic [LW-1:0] e;
    e = lg[g][i];
    check($sformatf("i%0d_log%0d_x2", g, i), 32'(e[3*DW-1:2*DW]), 32'(e2));
    check($sformatf("i%0d_log%0d_x3", g, i), 32'(e[2*DW-1:DW]), 32'(e3));
    check($sformatf("i%0d_log%0d_x4", g, i), 32'(e[DW-1:0]), 32'(e4));
    check($sformatf("i%0d_log%0d_sol", g, i), 32'(e[LW-1]), 32'(es));
    check($sformatf("i%0d_log%0d_eol", g, i), 32'(e[LW-2]), 32'(el));
    check($sformatf("i%0d_log%0d_eof", g, i), 32'(e[LW-3]), 32'(ef));
  endtask

  initial begin
    int base;
    rst = 1'b1; chk_en = 0; bub_en = 0; ordy_rnd = 0; ordy_hold = 0;
    for (int g = 0; g < NI; g++) wp[g] = 0;
    push(0, 164); push(0, 164); push(0, 164); push(0, 156);
    push(1, 164); push(1, 156); push(1, 148); push(1, 112);
    push(1, 132); push(1, 142); push(1, 10);  push(1, 20);
    push_rand(2, 8);

    // Reset held for three edges with in_valid high; nothing may be consumed.
    cyc(1);
    chk_en = 1;
    cyc(2);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("i%0d_rst_valid", g), 32'(ov[g]), 32'd0);
      check($sformatf("i%0d_rst_ready", g), 32'(ir[g]), 32'd1);
      check($sformatf("i%0d_rst_x2", g), 32'(ox2[g]), 32'd0);
      check($sformatf("i%0d_rst_x3", g), 32'(ox3[g]), 32'd0);
      check($sformatf("i%0d_rst_x4", g), 32'(ox4[g]), 32'd0);
      check($sformatf("i%0d_rst_flags", g), 32'({osol[g], oeol[g], oeof[g]}), 32'd0);
    end
    rst = 1'b0;

    wait_log(0, 2, 100);
    wait_log(1, 4, 100);
    check_log(0, 0, 164, 164, 164, 1, 0, 0);
    check_log(0, 1, 164, 156, 164, 0, 1, 1);
    check_log(1, 0, 164, 156, 148, 1, 0, 0);
    check_log(1, 1, 148, 112, 148, 0, 1, 0);
    check_log(1, 2, 132, 142, 10, 1, 0, 0);
    check_log(1, 3, 10, 20, 10, 0, 1, 1);

    // Frame wrap: the next row is row 0 again, so its eol carries no eof.
    push(1, 1); push(1, 2); push(1, 3); push(1, 4);
    wait_log(1, 6, 100);
    check_log(1, 4, 1, 2, 3, 1, 0, 0);
    check_log(1, 5, 3, 4, 3, 0, 1, 0);
    wait_drain(0, 100);
    wait_drain(2, 100);

    // Backpressure: triple pending with out_ready low; model compares every cycle.
    ordy_hold = 1;
    for (int g = 0; g < NI; g++) push_rand(g, rl(g));
    cyc(8);
    base = ln[2];
    cyc(5);
    check("i2_bp_no_transfer", 32'(ln[2]), 32'(base));
    for (int g = 0; g < NI; g++) begin
      check($sformatf("i%0d_bp_valid", g), 32'(ov[g]), 32'd1);
      check($sformatf("i%0d_bp_ready", g), 32'(ir[g]), 32'd0);
    end
    ordy_hold = 0;
    for (int g = 0; g < NI; g++) wait_drain(g, 200);

    // Random input bubbles and output backpressure over several frames.
    bub_en = 1; ordy_rnd = 1;
    for (int g = 0; g < NI; g++) push_rand(g, 2 * rl(g) * nr(g));
    for (int g = 0; g < NI; g++) wait_drain(g, 3000);
    bub_en = 0; ordy_rnd = 0;

    // Reset after s0..s2 of row 1, then a fresh row must start cleanly at row 0.
    push_rand(1, 4);
    push_rand(1, 3);
    wait_drain(1, 200);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    base = ln[1];
    push(1, 7); push(1, 8); push(1, 9); push(1, 10);
    wait_log(1, base + 2, 100);
    check_log(1, base, 7, 8, 9, 1, 0, 0);
    check_log(1, base + 1, 9, 10, 9, 0, 1, 0);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lift_window.md
# lift_window

Streaming sample sequencer that sits directly upstream of the `add_shift` 5/3 lifting stage. It accepts one row-major image sample per handshake and presents, per output beat, the even/odd/even triple `x2`, `x3`, `x4` that `add_shift` consumes. Symmetric extension is applied at the right row edge. Row and frame position are tracked internally and flagged on every output beat.

## Interface
Parameters:
- DATA_W, 19, sample width; matches `add_shift` operand width
- ROW_LEN, 256, samples per row; even, ≥ 4
- NUM_ROWS, 256, rows per frame; ≥ 1

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DATA_W  sample; passed through unmodified
- out_valid  out  1  triple valid
- out_ready  in  1  downstream accepts triple
- x2  out  DATA_W  left even sample s(2k)
- x3  out  DATA_W  odd sample s(2k+1)
- x4  out  DATA_W  right even sample s(2k+2), mirrored at row end
- out_sol  out  1  triple is k = 0 of its row
- out_eol  out  1  triple is k = ROW_LEN/2−1 of its row
- out_eof  out  1  out_eol on row NUM_ROWS−1

## Operation
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Row model: samples s0..s(ROW_LEN−1). Triple k = (s(2k), s(2k+1), s(2k+2)) for k < ROW_LEN/2−1. The last triple is (s(ROW_LEN−2), s(ROW_LEN−1), s(ROW_LEN−2)), i.e. x4 = x2.
- Internal registers: e_prev (last even sample), o_cur (last odd sample), col counter 0..ROW_LEN−1, row counter 0..NUM_ROWS−1.
- FSM states:
  - S_E0: await s0 of a row. in_ready = 1. On transfer: e_prev ← in_data, go to S_ODD.
  - S_ODD: await an odd sample. in_ready = 1. On transfer, if col = ROW_LEN−1: load x2 = e_prev, x3 = in_data, x4 = e_prev, set eol, go to S_OUT. Otherwise: o_cur ← in_data, go to S_EVEN.
  - S_EVEN: await s(2k+2). in_ready = 1. On transfer: load x2 = e_prev, x3 = o_cur, x4 = in_data; e_prev ← in_data; go to S_OUT.
  - S_OUT: out_valid = 1, in_ready = 0. On output transfer: go to S_E0 if eol, else go to S_ODD.
- col increments on every input transfer and wraps ROW_LEN−1 → 0.
- row increments when the eol triple transfers and wraps NUM_ROWS−1 → 0. Each frame restarts seamlessly, with no idle cycle.
- out_sol, out_eol and out_eof are registered together with x2/x3/x4.
- Arithmetic: none. No width change, no sign handling. Values are bit-exact copies of input samples.

## Timing
- Reset: out_valid = 0, in_ready = 1 (state S_E0), x2 = x3 = x4 = 0, all flags 0, col = row = 0. Reset overrides any in-flight transfer.
- Reset mid-row discards partial data; the next accepted sample is s0 of row 0.
- Latency: out_valid rises on the cycle after the completing input transfer (s(2k+2), or s(ROW_LEN−1) for the last triple).
- Triple outputs and flags are stable while out_valid = 1 and out_ready = 0. out_valid never drops without a transfer.
- in_ready is a pure function of state. It is 0 throughout S_OUT, so no input is accepted while a triple is pending.
- Throughput: 3 cycles per triple at full rate (2 input cycles plus 1 output cycle). The first triple of a row takes 4 cycles (s0, s1, s2, then output).
- in_valid deasserting mid-row only stalls the block; state and counters hold.
- out_ready may be high before out_valid. The transfer happens in the first S_OUT cycle.

## Test plan
- Reset: hold rst 3 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, x2/x3/x4 = 0. No sample is consumed during reset.
- Basic row, ROW_LEN = 4, NUM_ROWS = 1, out_ready = 1, stream 164, 164, 164, 156 → triple (164, 164, 164) with sol = 1; then (164, 156, 164) with eol = eof = 1. out_valid rises 1 cycle after the 3rd and 4th input transfers.
- Multi-row, ROW_LEN = 4, NUM_ROWS = 2, rows {164, 156, 148, 112} and {132, 142, 10, 20} → (164, 156, 148) sol; (148, 112, 148) eol, eof = 0; (132, 142, 10) sol; (10, 20, 10) eol, eof = 1. The next sample starts row 0 again.
- Backpressure: hold out_ready = 0 for 5 cycles while a triple is pending → outputs frozen, in_ready = 0, no input consumed. Releasing out_ready gives exactly one transfer.
- Input bubbles: random in_valid gaps (50%) with ROW_LEN = 8, compared against a reference model → identical triple sequence and flags.
- Reset mid-row: assert rst after s0..s2 of row 1 → the next outputs begin a fresh row 0 with sol = 1, and no stale e_prev/o_cur value appears.
